// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision add/sub unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: binary32 field widths, special-value encodings, the
// sign/exponent/mantissa struct and an infinity helper.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // Working significand: hidden bit + mantissa + guard/round/sticky.
  localparam int SIG_W = MAN_W + 4;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  function automatic logic [31:0] inf_of(input logic sign);
    return sign ? NEG_INF : POS_INF;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter over the 24-bit significand plus GRS bits.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of din.
// Ports: din - working significand; cnt - leading zeros (SIG_W when din is 0).
module fpu_lzc
  import fpu_pkg::*;
(
  input  logic [SIG_W-1:0] din,
  output logic [4:0]       cnt
);

  // Ascending scan: the highest set bit is the last to write cnt.
  always_comb begin
    cnt = 5'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (din[i]) cnt = 5'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_unit.sv
// IEEE-754 binary32 adder/subtractor with overflow/underflow flags and sticky copies.
// Latency: result and flags combinational (zero cycles); sticky flags update on posedge i_clk.
// Backpressure: none; operands may change every cycle.
// Ports: i_clk/i_rst_n (sticky regs only), i_add_sub (1 = A-B), i_32_a/i_32_b operands,
//        o_32_s result, o_ov_flag/o_un_flag current flags, o_ov_sticky/o_un_sticky accumulated flags.
module fpu_unit
  import fpu_pkg::*;
#(
  parameter int NUM_OP = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_add_sub,
  input  logic [31:0] i_32_a,
  input  logic [31:0] i_32_b,
  output logic [31:0] o_32_s,
  output logic        o_ov_flag,
  output logic        o_un_flag,
  output logic        o_ov_sticky,
  output logic        o_un_sticky
);

  // Every NUM_OP encoding currently selects add/sub, so subtraction is always enabled.
  localparam logic SUB_EN = (NUM_OP == 1) || (NUM_OP != 1);

  fp_t                a, b;
  logic               sb_eff;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [30:0]        mag_a, mag_b;
  logic               swap, l_sign, eff_sub;
  logic [EXP_W-1:0]   l_exp, s_exp, exp_diff;
  logic [MAN_W-1:0]   l_man, s_man;
  logic [SIG_W-1:0]   sig_l, sig_s, sig_s_al, shift_mask, norm;
  logic [SIG_W:0]     sum;
  logic [4:0]         lz;
  logic signed [9:0]  exp_n, exp_r;
  logic               round_up;
  logic [MAN_W+1:0]   man_rnd;
  logic [MAN_W-1:0]   man_out;

  assign a      = i_32_a;
  assign b      = i_32_b;
  assign sb_eff = b.sign ^ (i_add_sub & SUB_EN);

  // Subnormals are flushed: any zero exponent counts as a signed zero.
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);
  assign a_inf  = (a.exp == '1) && (a.man == '0);
  assign b_inf  = (b.exp == '1) && (b.man == '0);
  assign a_nan  = (a.exp == '1) && (a.man != '0);
  assign b_nan  = (b.exp == '1) && (b.man != '0);

  assign mag_a = a_zero ? '0 : {a.exp, a.man};
  assign mag_b = b_zero ? '0 : {b.exp, b.man};
  assign swap  = (mag_b > mag_a);

  assign l_sign   = swap ? sb_eff : a.sign;
  assign l_exp    = swap ? b.exp  : a.exp;
  assign l_man    = swap ? b.man  : a.man;
  assign s_exp    = swap ? a.exp  : b.exp;
  assign s_man    = swap ? a.man  : b.man;
  assign eff_sub  = a.sign ^ sb_eff;
  assign exp_diff = l_exp - s_exp;

  assign sig_l = {1'b1, l_man, 3'b000};
  assign sig_s = {1'b1, s_man, 3'b000};

  // Align the smaller operand; everything shifted out collapses into the sticky LSB.
  always_comb begin
    shift_mask = ~({SIG_W{1'b1}} << exp_diff);
    if (exp_diff >= 8'(SIG_W)) begin
      sig_s_al = {{(SIG_W-1){1'b0}}, 1'b1};
    end else begin
      sig_s_al = (sig_s >> exp_diff) | {{(SIG_W-1){1'b0}}, |(sig_s & shift_mask)};
    end
  end

  assign sum = eff_sub ? ({1'b0, sig_l} - {1'b0, sig_s_al})
                       : ({1'b0, sig_l} + {1'b0, sig_s_al});

  fpu_lzc u_lzc (
    .din (sum[SIG_W-1:0]),
    .cnt (lz)
  );

  // Carry out of the adder shifts right (keeping sticky); otherwise shift left by lz.
  always_comb begin
    if (sum[SIG_W]) begin
      norm  = {sum[SIG_W:2], sum[1] | sum[0]};
      exp_n = 10'(l_exp) + 10'sd1;
    end else begin
      norm  = sum[SIG_W-1:0] << lz;
      exp_n = 10'(l_exp) - 10'(lz);
    end
  end

  // Nearest-even: round up above half, or at exactly half when the kept LSB is odd.
  assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign man_rnd  = {1'b0, norm[SIG_W-1:3]} + (MAN_W+2)'(round_up);

  always_comb begin
    if (man_rnd[MAN_W+1]) begin
      exp_r   = exp_n + 10'sd1;
      man_out = man_rnd[MAN_W:1];
    end else begin
      exp_r   = exp_n;
      man_out = man_rnd[MAN_W-1:0];
    end
  end

  always_comb begin
    o_32_s    = {l_sign, exp_r[EXP_W-1:0], man_out};
    o_ov_flag = 1'b0;
    o_un_flag = 1'b0;
    if (a_nan || b_nan) begin
      o_32_s = QNAN;
    end else if (a_inf && b_inf && (a.sign != sb_eff)) begin
      o_32_s = QNAN;
    end else if (a_inf) begin
      o_32_s = inf_of(a.sign);
    end else if (b_inf) begin
      o_32_s = inf_of(sb_eff);
    end else if (a_zero && b_zero) begin
      o_32_s = {a.sign & sb_eff, 31'd0};
    end else if (a_zero) begin
      o_32_s = {sb_eff, b.exp, b.man};
    end else if (b_zero) begin
      o_32_s = i_32_a;
    end else if (sum == '0) begin
      o_32_s = 32'h00000000;
    end else if (exp_r >= 10'sd255) begin
      o_32_s    = inf_of(l_sign);
      o_ov_flag = 1'b1;
    end else if (exp_r < 10'sd1) begin
      o_32_s    = {l_sign, 31'd0};
      o_un_flag = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ov_sticky <= 1'b0;
      o_un_sticky <= 1'b0;
    end else begin
      o_ov_sticky <= o_ov_sticky | o_ov_flag;
      o_un_sticky <= o_un_sticky | o_un_flag;
    end
  end

endmodule

// File: tb/tb_fpu_unit.sv
// Bench for fpu_unit: directed vectors then randomized operands against an exact-integer model.
module tb_fpu_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_add_sub;
  logic [31:0] i_32_a, i_32_b;
  logic [31:0] o_32_s;
  logic        o_ov_flag, o_un_flag, o_ov_sticky, o_un_sticky;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  fpu_unit #(.NUM_OP(1)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_add_sub   (i_add_sub),
    .i_32_a      (i_32_a),
    .i_32_b      (i_32_b),
    .o_32_s      (o_32_s),
    .o_ov_flag   (o_ov_flag),
    .o_un_flag   (o_un_flag),
    .o_ov_sticky (o_ov_sticky),
    .o_un_sticky (o_un_sticky)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each finite operand becomes an exact integer in units of 2^-149,
  // the exact sum is formed, then rounded to 24 significant bits, nearest-even.
  // Returns {ov, un, result}.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic        sa, sb, rs;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [299:0] na, nb, mag, q, rem, half;
    int p, sh, e;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31] ^ sub; eb = b[30:23]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return {2'b00, 32'h7FC00000};
    if (ea == 8'hFF && eb == 8'hFF) return (sa != sb) ? {2'b00, 32'h7FC00000} : {2'b00, sa, 8'hFF, 23'd0};
    if (ea == 8'hFF) return {2'b00, sa, 8'hFF, 23'd0};
    if (eb == 8'hFF) return {2'b00, sb, 8'hFF, 23'd0};
    na = (ea == 0) ? '0 : (300'({1'b1, fa}) << (int'(ea) - 1));
    nb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (int'(eb) - 1));
    if (sa == sb) begin mag = na + nb; rs = sa; end
    else if (na >= nb) begin mag = na - nb; rs = sa; end
    else begin mag = nb - na; rs = sb; end
    if (mag == 0) return {2'b00, sa & sb, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    sh = p - 23;
    if (sh > 0) begin
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q[24]) begin q = q >> 1; p++; end
    end else begin
      q = mag << (-sh);
    end
    e = p - 22;
    if (e >= 255) return {2'b10, rs, 8'hFF, 23'd0};
    if (e < 1)    return {2'b01, rs, 31'd0};
    return {2'b00, rs, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp(input logic [31:0] other);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      3: r[30:23] = other[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
      4: r = {r[31], other[30:0] ^ 31'($urandom_range(0, 15))};
      5: r[30:23] = 8'($urandom_range(250, 254));
      6: r[30:23] = 8'($urandom_range(0, 3));
      7: case ($urandom_range(0, 5))
           0: r = 32'h00000000;
           1: r = 32'h80000000;
           2: r = 32'h7F800000;
           3: r = 32'hFF800000;
           4: r = {r[31], 8'hFF, r[22:1], 1'b1};
           default: r = {r[31], 8'h00, r[22:0]};
         endcase
      default: ;
    endcase
    return r;
  endfunction

  // Drive, check combinational outputs, then advance one clock.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] exp_s, input logic exp_ov, input logic exp_un);
    i_32_a = a; i_32_b = b; i_add_sub = sub;
    #2;
    check(tag, {30'd0, o_ov_flag, o_un_flag, o_32_s}, {30'd0, exp_ov, exp_un, exp_s});
    @(posedge i_clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [33:0] r;
    logic [31:0] ra, rb;
    logic        rsub, m_ov, m_un;

    i_rst_n = 1'b0; i_add_sub = 1'b0; i_32_a = '0; i_32_b = '0;
    #3;
    check("reset_sticky", {62'd0, o_ov_sticky, o_un_sticky}, 64'd0);
    // Combinational path is live while reset is held.
    step("in_reset_add", 32'h40B00000, 32'h400CCCCD, 1'b0, 32'h40F66666, 1'b0, 1'b0);
    i_rst_n = 1'b1;

    step("zero_pp",   32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    step("zero_pn",   32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    step("zero_sub",  32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    step("nzero_sub", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
    step("inf_add",   32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
    step("inf_sub",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0);
    step("inf_pn",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
    step("inf_pn_s",  32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b0);
    step("tie_even",  32'h40B00000, 32'h400CCCCD, 1'b0, 32'h40F66666, 1'b0, 1'b0);
    step("sub_pos",   32'h40B00000, 32'h400CCCCD, 1'b1, 32'h40533333, 1'b0, 1'b0);
    step("sub_neg",   32'h400CCCCD, 32'h40B00000, 1'b1, 32'hC0533333, 1'b0, 1'b0);
    step("neg_add",   32'hC0B00000, 32'hC0B00000, 1'b0, 32'hC1300000, 1'b0, 1'b0);
    step("cancel",    32'hC0B00000, 32'hC0B00000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    step("rnd_carry", 32'hC07FFFFF, 32'hC1F00000, 1'b0, 32'hC2080000, 1'b0, 1'b0);
    step("rnd_sub",   32'hC1F00000, 32'hC07FFFFF, 1'b1, 32'hC1D00000, 1'b0, 1'b0);
    step("nan_in",    32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
    step("subn_ftz",  32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    check("sticky_quiet", {62'd0, o_ov_sticky, o_un_sticky}, 64'd0);

    step("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    check("ov_sticky_set", {62'd0, o_ov_sticky, o_un_sticky}, 64'd2);
    step("after_ov",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    check("ov_sticky_hold", {62'd0, o_ov_sticky, o_un_sticky}, 64'd2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("ov_sticky_async_clr", {62'd0, o_ov_sticky, o_un_sticky}, 64'd0);
    step("ov_in_reset", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    check("sticky_held_in_reset", {62'd0, o_ov_sticky, o_un_sticky}, 64'd0);
    i_32_a = 32'h3F800000; i_32_b = 32'h3F800000;
    i_rst_n = 1'b1;

    step("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1);
    check("un_sticky_set", {62'd0, o_ov_sticky, o_un_sticky}, 64'd1);

    i_rst_n = 1'b0; #2; i_rst_n = 1'b1;
    m_ov = 1'b0; m_un = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ra   = rand_fp($urandom);
      rb   = rand_fp(ra);
      rsub = 1'($urandom_range(0, 1));
      r    = ref_add(ra, rb, rsub);
      step($sformatf("rand%0d_%h_%h_%0d", i, ra, rb, rsub), ra, rb, rsub, r[31:0], r[33], r[32]);
      m_ov = m_ov | r[33];
      m_un = m_un | r[32];
      check($sformatf("rand_sticky%0d", i), {62'd0, o_ov_sticky, o_un_sticky}, {62'd0, m_ov, m_un});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_unit.md
# fpu_unit

Combinational IEEE-754 single-precision adder/subtractor with overflow and underflow flags, plus registered sticky copies of those flags. It is the arithmetic core of the floating-point block. Operands are driven directly by the surrounding datapath, which in test is a pair of ROM-fed operand sources. The result is valid in the same cycle the operands are applied.

## Interface
- NUM_OP, default 1: number of supported operations. 1 = add/sub. Other values are reserved and must behave as 1.
- i_clk  in  1  clock; used only by the sticky flag registers.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_add_sub  in  1  0 = A+B, 1 = A−B.
- i_32_a  in  32  operand A, IEEE-754 binary32.
- i_32_b  in  32  operand B, IEEE-754 binary32.
- o_32_s  out  32  result, binary32; combinational.
- o_ov_flag  out  1  overflow for the current operands; combinational.
- o_un_flag  out  1  underflow for the current operands; combinational.
- o_ov_sticky  out  1  registered OR of o_ov_flag since reset.
- o_un_sticky  out  1  registered OR of o_un_flag since reset.

## Operation
- Effective B sign = b[31] XOR i_add_sub.
- Subnormal inputs are treated as ±0 (flush-to-zero on input).
- Datapath:
  - Swap operands so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits.
  - Add or subtract mantissas.
  - Normalize with a leading-zero count.
  - Round to nearest, ties to even.
  - Renormalize on a rounding carry.
- Special cases, in priority order:
  - Any NaN input → 32'h7FC00000.
  - +inf plus −inf (effective) → 32'h7FC00000. No flags.
  - One or two infinities with the same effective sign → that infinity. No flags.
  - Exact cancellation, including 0 + (−0) and x − x → +0 (32'h00000000).
  - (−0) + (−0) → 32'h80000000.
  - 0 op x → ±x with the effective sign.
- Overflow:
  - Condition: finite operands and rounded exponent ≥ 255.
  - Result ±inf (exp 8'hFF, mantissa 0), o_ov_flag = 1.
- Underflow:
  - Condition: nonzero result whose rounded exponent is < 1.
  - Result ±0 keeping the result sign, o_un_flag = 1.
- Flags are 0 in every other case.

## Timing
- o_32_s, o_ov_flag and o_un_flag are purely combinational from the inputs: zero latency, settled within half a clock period.
- No handshake. Inputs may change every cycle.
- Sticky flags:
  - On each posedge i_clk: o_ov_sticky |= o_ov_flag and o_un_sticky |= o_un_flag.
  - i_rst_n low clears both to 0 immediately (asynchronous).
  - Reset mid-operation does not affect the combinational outputs.
- Reset values: o_ov_sticky = 0, o_un_sticky = 0. The other outputs follow the inputs.

## Structure
- Shared package fpu_pkg holds:
  - Field widths (EXP_W = 8, MAN_W = 23, BIAS = 127).
  - Constants QNAN = 32'h7FC00000, POS_INF = 32'h7F800000, NEG_INF = 32'hFF800000.
  - A typedef for the sign/exponent/mantissa struct.
- One natural sub-module: fpu_lzc, the 24-bit+GRS leading-zero counter used for normalization.
- The stimulus ROM (single_port_rom) is test infrastructure and is not part of this block.

## Test plan
- Zeros:
  - 0 + 0 → 32'h00000000.
  - 0 + 80000000 → 32'h00000000.
  - 0 − 80000000 → 32'h00000000.
  - 80000000 − 0 → 32'h80000000.
  - All with flags 0.
- Infinities:
  - 7F800000 + 7F800000 → 7F800000.
  - 7F800000 − 7F800000 → 7FC00000.
  - 7F800000 + FF800000 → 7FC00000.
  - 7F800000 − FF800000 → 7F800000.
- Normal values:
  - 40B00000 + 400CCCCD → 40F66666 (tie rounds to even).
  - 40B00000 − 400CCCCD → 40533333.
  - 400CCCCD − 40B00000 → C0533333.
  - C0B00000 + C0B00000 → C1300000.
  - C0B00000 − C0B00000 → 00000000.
- Rounding carry: C07FFFFF + C1F00000 → C2080000; C1F00000 − C07FFFFF → C1D00000.
- Overflow and sticky:
  - 7F7FFFFF + 7F7FFFFF → 7F800000, o_ov_flag = 1.
  - o_ov_sticky = 1 after the next posedge and stays 1 after the operands return to normal values.
  - Asserting i_rst_n low clears o_ov_sticky asynchronously.
- Underflow:
  - 00800001 − 00800000 → 00000000, o_un_flag = 1.
  - o_un_sticky = 1 after the next posedge.
